deser_frame_ctrl: RTL and testbench
===================================

// Module: deser_frame_ctrl
// PURPOSE
//  Controller for the WIDTH-bit serial-in/parallel-out shift register in the receive path.
//  Hunts for a sync word in the incoming bit stream, then collects FRAME_WORDS words and
//  delivers each to the downstream framer over a valid/ready handshake.
//  Drives the register's load/seed/data inputs to clear, hold or shift it; the register
//  itself has no enable.
// PARAMETERS
//  WIDTH        8      word width; also the sync-word width (>=2)
//  SYNC_WORD    8'hA5  sync pattern, received MSB first
//  FRAME_WORDS  4      payload words per frame (>=1)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  rx_bit       in   1      serial data, sampled only when rx_bit_en=1
//  rx_bit_en    in   1      bit strobe (may have arbitrary gaps)
//  start        in   1      arm the receiver; honoured in IDLE only
//  abort        in   1      drop the frame; honoured in any state
//  word_data    out  WIDTH  output holding register
//  word_valid   out  1      word_data valid
//  word_ready   in   1      downstream accepts the word when word_valid&word_ready
//  word_last    out  1      qualifies word_valid: last word of the frame
//  busy         out  1      state != IDLE
//  locked       out  1      sync found, frame in progress (COLLECT/DRAIN)
//  overrun      out  1      sticky; cleared by an accepted start
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; shift reg=0; all outputs 0, including word_data; counters=0.
//  - Shift-reg control: shift = load 0, data=rx_bit; hold = load 1, seed=q; clear = load 1, seed=0.
//    The register shifts toward the MSB, so the first bit received ends in bit WIDTH-1.
//  - nxt = {q[WIDTH-2:0], rx_bit}; all compares and captures use nxt on the strobe edge.
//  - IDLE: hold. start -> clear the register, clear overrun, go to HUNT. A strobe in the start cycle is ignored.
//  - HUNT: shift on each strobe; fill_cnt saturates at WIDTH.
//    On a strobe where fill_cnt>=WIDTH-1 and nxt==SYNC_WORD -> COLLECT, bit_cnt=0, word_cnt=0.
//  - COLLECT: shift on each strobe; bit_cnt++. On the strobe where bit_cnt==WIDTH-1:
//    capture nxt; bit_cnt=0; word_cnt++.
//    If word_cnt==FRAME_WORDS-1, that capture is the last word; go to DRAIN.
//  - Capture: word_valid=1 and word_data=nxt the next cycle (1-cycle latency after the strobe).
//    word_last is set for the last word.
//  - Capture while holding an unaccepted word (valid & !ready in the same cycle):
//    the new word is dropped, the held word is kept, and overrun<=1.
//    Same-cycle accept plus capture: the new word replaces the old one; no overrun.
//  - DRAIN: hold; ignore strobes; go to IDLE in the cycle after the last word is accepted
//    or dropped, with word_valid=0.
//  - Handshake: word_valid/word_data/word_last stay stable until accepted;
//    valid drops the cycle after acceptance unless a new word is captured.
//  - abort (priority over all): state<=IDLE, register clear, word_valid/word_last/locked<=0,
//    counters 0; overrun kept.
//  - start while busy: ignored. start and abort together: abort wins; stay IDLE.
//  - Counters use $clog2(WIDTH+1) and $clog2(FRAME_WORDS+1) bits; no wrap in normal use.
//  - Async reset mid-frame: immediate return to the reset values; the partial frame is lost.
// STRUCTURE
//  - Shared package/header: state encoding (IDLE, HUNT, COLLECT, DRAIN), default WIDTH,
//    default SYNC_WORD.
//  - One sub-module: the team's existing SIPO shift register, instantiated with n=WIDTH.
//    FSM, counters and holding register are in this file.
// TESTING (WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=2 unless noted)
//  1 Assert reset mid-COLLECT -> all outputs 0 at once; busy=0 after release; restart works.
//  2 start; bits 1,1,0 then A5,12,34 MSB first, word_ready=1
//    -> word 8'h12 then 8'h34 with word_last=1; busy=0 after the last accept; overrun=0.
//  3 Same stream, strobe every 3rd cycle, with start asserted on a strobe cycle
//    -> that bit is ignored; the output matches scenario 2.
//  4 word_ready=0 until after the second capture -> 8'h12 held stable; overrun=1;
//    8'h34 never appears; IDLE after 8'h12 is accepted.
//  5 Stream 7 bits of A5 then a sync found only on later true bits
//    -> no false lock before 8 bits received (fill_cnt gate).
//  6 abort after 4 COLLECT bits -> next cycle IDLE, locked=0, word_valid=0;
//    a new start then frame 8'h56,8'h78 is received correctly.

Source files
------------

// File: rtl/deser_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// deser_frame_ctrl_pkg
//   Shared definitions for the receive-path deserialiser frame controller:
//   FSM state encoding and the default word width / sync pattern.
// -----------------------------------------------------------------------------
package deser_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int         DEFAULT_WIDTH     = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/deser_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// deser_frame_ctrl_if
//   Word delivery bus from the frame controller to the downstream framer.
//   Ports (signals):
//     word_data  [WIDTH]  holding register contents
//     word_valid          word_data is valid
//     word_last           qualifies word_valid: last word of the frame
//     word_ready          downstream accepts when word_valid & word_ready
//   Modports: master = controller side, slave = framer side.
// -----------------------------------------------------------------------------
interface deser_frame_ctrl_if
    import deser_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_last;
    logic             word_ready;

    modport master (
        output word_data,
        output word_valid,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        input  word_last,
        output word_ready
    );

endinterface

// File: rtl/deser_frame_ctrl_sipo.sv
// -----------------------------------------------------------------------------
// deser_frame_ctrl_sipo
//   Serial-in/parallel-out shift register with no enable. Every clock it either
//   loads seed (load=1) or shifts data in at bit 0 toward the MSB (load=0).
//   Holding is done by the caller loading q back as seed.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset (q <= 0)
//     load   in   1: q <= seed, 0: q <= {q[n-2:0], data}
//     seed   in   parallel load value
//     data   in   serial input bit
//     q      out  register contents
// -----------------------------------------------------------------------------
module deser_frame_ctrl_sipo #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] seed,
    input  logic         data,
    output logic [n-1:0] q
);

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else begin
            q <= {q[n-2:0], data};
        end
    end

endmodule

// File: rtl/deser_frame_ctrl.sv
// -----------------------------------------------------------------------------
// deser_frame_ctrl
//   Receive-path deserialiser controller. Hunts for SYNC_WORD in the strobed
//   serial stream, then collects FRAME_WORDS words of WIDTH bits and presents
//   each on a valid/ready bus. Drives the SIPO register's load/seed/data to
//   clear, hold or shift it.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     rx_bit     in   serial data, sampled when rx_bit_en=1
//     rx_bit_en  in   bit strobe (arbitrary gaps allowed)
//     start      in   arm the receiver (honoured in IDLE only)
//     abort      in   drop the frame, highest priority, any state
//     word_if    master side of the word bus (data/valid/last out, ready in)
//     busy       out  state != IDLE
//     locked     out  sync found, frame in progress (COLLECT/DRAIN)
//     overrun    out  sticky: a captured word was dropped; cleared by start
// -----------------------------------------------------------------------------
module deser_frame_ctrl
    import deser_frame_ctrl_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEFAULT_SYNC_WORD),
    parameter int               FRAME_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_bit,
    input  logic               rx_bit_en,
    input  logic               start,
    input  logic               abort,
    deser_frame_ctrl_if.master word_if,
    output logic               busy,
    output logic               locked,
    output logic               overrun
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int WCW = $clog2(FRAME_WORDS + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] FILL_FULL = BCW'(WIDTH);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    state_t           state;
    logic [BCW-1:0]   fill_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [WCW-1:0]   word_cnt;

    logic             sr_load;
    logic [WIDTH-1:0] sr_seed;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] nxt;
    logic             accept;
    logic             cap_last;

    // Register contents as they will be after this strobe; sync compare and
    // word capture both look at this so they see the bit arriving now.
    assign nxt      = {sr_q[WIDTH-2:0], rx_bit};
    assign accept   = word_if.word_valid & word_if.word_ready;
    assign cap_last = (word_cnt == WORD_LAST);

    deser_frame_ctrl_sipo #(
        .n (WIDTH)
    ) u_sipo (
        .clk   (clk),
        .reset (reset),
        .load  (sr_load),
        .seed  (sr_seed),
        .data  (rx_bit),
        .q     (sr_q)
    );

    // Shift-register control: hold by default (load own value back), clear on
    // abort or accepted start, shift only on strobes while hunting/collecting.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sr_load = 1'b1;
        sr_seed = sr_q;
        if (abort) begin
            sr_seed = '0;
        end else begin
            unique case (state)
                ST_IDLE:            if (start) sr_seed = '0;
                ST_HUNT, ST_COLLECT: if (rx_bit_en) sr_load = 1'b0;
                default:            ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            fill_cnt           <= '0;
            bit_cnt            <= '0;
            word_cnt           <= '0;
            word_if.word_data  <= '0;
            word_if.word_valid <= 1'b0;
            word_if.word_last  <= 1'b0;
            busy               <= 1'b0;
            locked             <= 1'b0;
            overrun            <= 1'b0;
        end else if (abort) begin
            // overrun deliberately survives an abort; only start clears it.
            state              <= ST_IDLE;
            fill_cnt           <= '0;
            bit_cnt            <= '0;
            word_cnt           <= '0;
            word_if.word_valid <= 1'b0;
            word_if.word_last  <= 1'b0;
            busy               <= 1'b0;
            locked             <= 1'b0;
        end else begin
            // Acceptance retires the held word; a capture below in the same
            // cycle overrides this with the new word.
            if (accept) begin
                word_if.word_valid <= 1'b0;
                word_if.word_last  <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_HUNT;
                        busy     <= 1'b1;
                        overrun  <= 1'b0;
                        fill_cnt <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end

                ST_HUNT: begin
                    if (rx_bit_en) begin
                        if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + BCW'(1);
                        // fill_cnt gate: nxt only holds real bits once WIDTH
                        // of them have been shifted in since start.
                        if (fill_cnt >= BIT_LAST && nxt == SYNC_WORD) begin
                            state    <= ST_COLLECT;
                            locked   <= 1'b1;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (rx_bit_en) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt + WCW'(1);
                            if (!word_if.word_valid || word_if.word_ready) begin
                                word_if.word_data  <= nxt;
                                word_if.word_valid <= 1'b1;
                                word_if.word_last  <= cap_last;
                            end else begin
                                // Held word not taken yet: keep it, drop the new one.
                                overrun <= 1'b1;
                            end
                            if (cap_last) state <= ST_DRAIN;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    if (!word_if.word_valid || accept) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        locked   <= 1'b0;
                        fill_cnt <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_deser_frame_ctrl
//   Directed bench for deser_frame_ctrl (WIDTH=8, SYNC_WORD=A5, FRAME_WORDS=2).
//   Stimulus pushes expected words into a queue; a negedge monitor pops and
//   compares each word as it is accepted and checks held words stay stable.
// -----------------------------------------------------------------------------
module tb_deser_frame_ctrl;

    localparam int WIDTH       = 8;
    localparam int FRAME_WORDS = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_bit = 1'b0;
    logic rx_bit_en = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic locked;
    logic overrun;

    deser_frame_ctrl_if #(.WIDTH(WIDTH)) word_if ();

    deser_frame_ctrl #(
        .WIDTH       (WIDTH),
        .SYNC_WORD   (8'hA5),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_bit    (rx_bit),
        .rx_bit_en (rx_bit_en),
        .start     (start),
        .abort     (abort),
        .word_if   (word_if),
        .busy      (busy),
        .locked    (locked),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: a word is taken at the posedge after a negedge with valid&ready.
    logic       stall_prev = 1'b0;
    logic [8:0] held_prev  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset && word_if.word_valid) begin
            if (stall_prev) check("hold_stable", {word_if.word_data, word_if.word_last}, held_prev);
            if (word_if.word_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL word_unexpected: got %0h expected none (t=%0t)", word_if.word_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("word_data", word_if.word_data, e.data);
                    check("word_last", word_if.word_last, e.last);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held_prev  = {word_if.word_data, word_if.word_last};
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        rx_bit    = b;
        rx_bit_en = 1'b1;
        tick();
        rx_bit_en = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        word_if.word_ready = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", word_if.word_valid, 0);
        check("rst_data", word_if.word_data, 0);
        check("rst_overrun", overrun, 0);
        tick();
        reset = 1'b1;
        tick();

        // Scenario 2: preamble 1,1,0 then A5, 12, 34 back to back.
        push(8'h12, 1'b0);
        push(8'h34, 1'b1);
        do_start();
        check("s2_busy", busy, 1);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_byte(8'hA5, 0);
        check("s2_locked", locked, 1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        wait_idle("s2_idle");
        check("s2_overrun", overrun, 0);
        check("s2_locked_off", locked, 0);

        // Scenario 3: same stream, strobe every 3rd cycle, strobe on start cycle.
        push(8'h12, 1'b0);
        push(8'h34, 1'b1);
        start = 1'b1; rx_bit = 1'b1; rx_bit_en = 1'b1;
        tick();
        start = 1'b0; rx_bit_en = 1'b0;
        tick(); tick();
        send_bit(1'b1, 2); send_bit(1'b1, 2); send_bit(1'b0, 2);
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        send_byte(8'h34, 2);
        wait_idle("s3_idle");

        // Scenario 4: downstream stalls, second word is dropped.
        word_if.word_ready = 1'b0;
        push(8'h12, 1'b0);
        do_start();
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        tick();
        check("s4_overrun", overrun, 1);
        check("s4_valid", word_if.word_valid, 1);
        check("s4_data", word_if.word_data, 8'h12);
        check("s4_last", word_if.word_last, 0);
        check("s4_busy", busy, 1);
        word_if.word_ready = 1'b1;
        wait_idle("s4_idle");
        tick();
        check("s4_valid_off", word_if.word_valid, 0);

        // abort in IDLE keeps the sticky overrun.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_keeps_overrun", overrun, 1);

        // Scenario 6: abort four bits into COLLECT, then a clean frame.
        do_start();
        check("s6_start_clears_ovr", overrun, 0);
        send_byte(8'hA5, 0);
        check("s6_locked", locked, 1);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("s6_busy", busy, 0);
        check("s6_locked_off", locked, 0);
        check("s6_valid", word_if.word_valid, 0);
        push(8'h56, 1'b0);
        push(8'h78, 1'b1);
        do_start();
        send_byte(8'hA5, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        wait_idle("s6_idle");

        // Scenario 5: partial sync first, real sync only after 16 bits.
        push(8'h9A, 1'b0);
        push(8'hBC, 1'b1);
        do_start();
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        check("s5_no_lock7", locked, 0);
        send_bit(1'b0, 0);
        check("s5_no_lock8", locked, 0);
        send_byte(8'hA5, 0);
        check("s5_lock", locked, 1);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        wait_idle("s5_idle");

        // Scenario 1: async reset mid-COLLECT with a word held.
        word_if.word_ready = 1'b0;
        do_start();
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        check("s1_pre_valid", word_if.word_valid, 1);
        #3 reset = 1'b0;
        #1;
        check("s1_busy", busy, 0);
        check("s1_locked", locked, 0);
        check("s1_valid", word_if.word_valid, 0);
        check("s1_last", word_if.word_last, 0);
        check("s1_data", word_if.word_data, 0);
        check("s1_overrun", overrun, 0);
        tick();
        reset = 1'b1;
        word_if.word_ready = 1'b1;
        tick();
        check("s1_busy_after", busy, 0);
        push(8'h12, 1'b0);
        push(8'h34, 1'b1);
        do_start();
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        wait_idle("s1_idle");

        repeat (5) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
